// File: rtl/div_seq.sv
// div_seq: iterative signed/unsigned restoring divider for the execute stage.
// One quotient bit per cycle; holds the pipeline via stall_o until done.
// result_o = {remainder, quotient}. It is driven only in END and is zero
// otherwise, so it can be OR-merged with the other HI/LO sources.
// Optional feature macro: DIV_EARLY_TERM_EN. When it is defined, an operation
// with |dividend| < |divisor| goes straight to END without stepping.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quot_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic               neg_quot_reg;
  logic               neg_rem_reg;
  logic [2*WIDTH-1:0] result_reg;

  // Request qualified by flush; a flush always wins over a request.
  logic go;
  assign go = start_i & ~annul_i;

  logic div_zero;
  assign div_zero = (opdata2_i == '0);

  // Operand magnitudes. In signed mode a negative operand is replaced by its
  // two's-complement negation. 0x80000000 stays 0x80000000, which is the
  // correct unsigned magnitude.
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (signed_i & opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag_b = (signed_i & opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // Early termination: when the dividend magnitude is below the divisor
  // magnitude, the quotient is zero and the remainder is the dividend itself.
  logic early_term;
`ifdef DIV_EARLY_TERM_EN
  assign early_term = (mag_a < mag_b);
`else
  assign early_term = 1'b0;
`endif

  // One restoring step. Shift {rem, quot} left by one, then trial-subtract the
  // divisor. The partial remainder always stays below the divisor, so one
  // extra bit is enough to catch the borrow.
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic             last_step;

  assign partial   = {rem_reg, quot_reg[WIDTH-1]};
  assign diff      = partial - {1'b0, divisor_reg};
  assign step_rem  = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quot = {quot_reg[WIDTH-2:0], ~diff[WIDTH]};
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  // Sign fix-up applied to the final step's output. Both flags are zero for
  // DIVU, so unsigned results pass through unchanged.
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign quot_fix = neg_quot_reg ? (~step_quot + 1'b1) : step_quot;
  assign rem_fix  = neg_rem_reg  ? (~step_rem  + 1'b1) : step_rem;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. A flush returns to IDLE from every state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (go) begin
          if (div_zero)        state_next = S_BYZERO;
          else if (early_term) state_next = S_END;
          else                 state_next = S_ON;
        end
      end
      S_BYZERO: state_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)        state_next = S_IDLE;
        else if (last_step) state_next = S_END;
      end
      S_END: begin
        if (annul_i | ~start_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs. The result is gated to zero outside END for OR-merging.
  always_comb begin
    ready_o  = (state_reg == S_END);
    result_o = ready_o ? result_reg : '0;
    stall_o  = go & (state_reg != S_END);
  end

  // Datapath: operand latching, step iteration and final result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      divisor_reg  <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (go) begin
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quot_reg     <= mag_a;
            divisor_reg  <= mag_b;
            neg_quot_reg <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_reg  <= signed_i & opdata1_i[WIDTH-1];
            result_reg   <= early_term ? {opdata1_i, {WIDTH{1'b0}}} : '0;
          end
        end
        S_BYZERO: result_reg <= '0;
        S_ON: begin
          if (!annul_i) begin
            rem_reg  <= step_rem;
            quot_reg <= step_quot;
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_step) result_reg <= {rem_fix, quot_fix};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq. A plain-arithmetic reference model
// gives the result and the latency of each operation. A per-cycle phase model
// (busy / end / idle) drives a single negedge compare process that checks
// ready_o, stall_o and result_o.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stall_o;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .annul_i(annul_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // phase: 0 = idle (no result), 1 = busy, 2 = result presented.
  int          phase = 0;
  logic [63:0] model_res = '0;
  logic        exp_ready, exp_stall;
  logic [63:0] exp_res;

  // Reference quotient and remainder from language arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else begin
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      q = sq; r = sr;
    end
    return {r, q};
  endfunction

  // Cycle index at which ready_o must first be seen (cycle 0 = request).
  function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? (~a + 32'd1) : a;
    mb = (s && b[31]) ? (~b + 32'd1) : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 1;
`else
    if (ma < mb && ma == 32'hFFFFFFFF) return 0;
`endif
    return 33;
  endfunction

  task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Per-cycle compare against the phase model.
  always @(negedge clk) begin
    exp_ready = (phase == 2);
    exp_res   = exp_ready ? model_res : 64'd0;
    exp_stall = start_i & ~annul_i & (phase != 2);
    vectors++;
    if (ready_o !== exp_ready || stall_o !== exp_stall || result_o !== exp_res) begin
      miscompares++;
      $display("FAIL cycle t=%0t a=%h b=%h: ready %b want %b, stall %b want %b, result %h want %h",
               $time, opdata1_i, opdata2_i, ready_o, exp_ready, stall_o, exp_stall, result_o, exp_res);
    end
  end

  // Run one operation starting in the current cycle. annul_at / rst_at give
  // the cycle in which a flush or reset is pulsed (-1 for none).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int annul_at, input int rst_at);
    int  lat;
    int  k;
    bit  fired;
    lat = latency(a, b, s);
    model_res = model(a, b, s);
    opdata1_i = a; opdata2_i = b; signed_i = s; start_i = 1'b1;
    phase = 1; k = 0; fired = 0;
    for (int guard = 0; guard < 200; guard++) begin
      @(posedge clk); #1;
      k++;
      if (annul_i) begin
        annul_i = 1'b0; start_i = 1'b0; phase = 0;
        @(posedge clk); #1;
        $display("op %s %h / %h : annulled", s ? "DIV " : "DIVU", a, b);
        return;
      end
      if (rst) begin
        rst = 1'b0; k = 0; phase = 1;
        continue;
      end
      if (!fired && k == annul_at) begin annul_i = 1'b1; fired = 1; end
      if (!fired && k == rst_at)   begin rst = 1'b1;     fired = 1; end
      if (k == lat) phase = 2;
      if (k == lat + 1) start_i = 1'b0;
      if (k == lat + 2) begin
        phase = 0;
        $display("op %s %h / %h : result %h latency %0d", s ? "DIV " : "DIVU", a, b, model_res, lat);
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL timeout op %h / %h", a, b);
    start_i = 1'b0; phase = 0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed values that pin the reference model.
    pin("m_divu_100_7",  model(32'd100, 32'd7, 1'b0),               64'h00000002_0000000E);
    pin("m_div_m7_2",    model(32'hFFFFFFF9, 32'd2, 1'b1),          64'hFFFFFFFF_FFFFFFFD);
    pin("m_div_7_m2",    model(32'd7, 32'hFFFFFFFE, 1'b1),          64'h00000001_FFFFFFFD);
    pin("m_div_min_m1",  model(32'h80000000, 32'hFFFFFFFF, 1'b1),   64'h00000000_80000000);
    pin("m_divu_by0",    model(32'd1234, 32'd0, 1'b0),              64'd0);
    pin("m_divu_5_9",    model(32'd5, 32'd9, 1'b0),                 64'h00000005_00000000);
    pin("m_divu_9_3",    model(32'd9, 32'd3, 1'b0),                 64'h00000000_00000003);
    pin("lat_full",      64'(latency(32'd100, 32'd7, 1'b0)),        64'd33);
    pin("lat_by0",       64'(latency(32'd1234, 32'd0, 1'b0)),       64'd2);
`ifdef DIV_EARLY_TERM_EN
    pin("lat_early",     64'(latency(32'd5, 32'd9, 1'b0)),          64'd1);
`else
    pin("lat_early",     64'(latency(32'd5, 32'd9, 1'b0)),          64'd33);
`endif

    do_op(32'd100,        32'd7,          1'b0, -1, -1);
    do_op(32'hFFFFFFF9,   32'd2,          1'b1, -1, -1);
    do_op(32'd7,          32'hFFFFFFFE,   1'b1, -1, -1);
    do_op(32'd1234,       32'd0,          1'b0, -1, -1);
    do_op(32'h80000000,   32'hFFFFFFFF,   1'b1, -1, -1);
    do_op(32'hFFFFFFFF,   32'd3,          1'b0, 10, -1);
    do_op(32'd9,          32'd3,          1'b0, -1, -1);
    do_op(32'd5,          32'd9,          1'b0, -1, -1);
    do_op(32'hDEADBEEF,   32'h00001234,   1'b0, -1, 20);
    do_op(32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, -1, -1);
    do_op(32'hFFFFFFFB,   32'd9,          1'b1, -1, -1);
    do_op(32'hFFFFFFFF,   32'd1,          1'b0, -1, -1);
    do_op(32'h80000000,   32'd1,          1'b1, -1, -1);
    do_op(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, -1, -1);
    do_op(32'd0,          32'd5,          1'b1, -1, -1);
    do_op(32'h7FFFFFFF,   32'h80000000,   1'b1, -1, -1);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
